// File: rtl/pic_fetch_if.sv
// Program ROM bus between the fetch front end (master) and the
// combinational program ROM (slave).
interface pic_fetch_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/pic_fetch.sv
// Instruction-fetch front end for the 12-bit PIC core.
// It owns the PC, the 2-level return stack, the IR and the pipeline flushes.
module pic_fetch #(
  parameter int              ADDR_W       = 9,
  parameter int              DATA_W       = 12,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR    = '0
) (
  input  logic              clk,
  input  logic              rst,
  pic_fetch_if.master       rom,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call_en,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret_en,
  input  logic              pc_wr_en,
  input  logic [ADDR_W-1:0] pc_wr_data,
  input  logic              skip_en,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        stack_depth,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  logic [ADDR_W-1:0] stack1;
  logic [ADDR_W-1:0] stack2;
  logic              redirect;
  logic [ADDR_W-1:0] target;

  assign rom.rom_addr = pc;
  assign redirect     = ret_en | call_en | jump_en | pc_wr_en;

  // Redirect priority: ret > call > jump > pc write.
  always_comb begin
    target = pc_wr_data;
    if (ret_en)       target = stack1;
    else if (call_en) target = call_addr;
    else if (jump_en) target = jump_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= RESET_VECTOR;
      instr           <= NOP_INSTR;
      instr_pc        <= '0;
      instr_valid     <= 1'b0;
      stack1          <= '0;
      stack2          <= '0;
      stack_depth     <= 2'd0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (redirect) begin
      // A redirect beats both stall and skip; the fetched word is flushed.
      pc          <= target;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_pc    <= pc;
      if (ret_en) begin
        stack1 <= stack2;
        if (stack_depth == 2'd0) stack_underflow <= 1'b1;
        else                     stack_depth     <= stack_depth - 2'd1;
      end else if (call_en) begin
        stack2 <= stack1;
        stack1 <= pc;
        if (stack_depth == 2'd2) stack_overflow <= 1'b1;
        else                     stack_depth    <= stack_depth + 2'd1;
      end
    end else if (!stall) begin
      pc       <= pc + 1'b1;
      instr_pc <= pc;
      if (skip_en) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end else begin
        instr       <= rom.rom_data;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_fetch.sv
// Directed bench for pic_fetch; the ROM model returns {3'b101, addr}.
module tb_pic_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jump_en, call_en, ret_en, pc_wr_en, skip_en;
  logic [8:0]  jump_addr, call_addr, pc_wr_data;
  logic [11:0] instr;
  logic [8:0]  instr_pc, pc;
  logic        instr_valid;
  logic [1:0]  stack_depth;
  logic        stack_overflow, stack_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pic_fetch_if #(.ADDR_W(9), .DATA_W(12)) rom_bus ();
  assign rom_bus.rom_data = {3'b101, rom_bus.rom_addr};

  pic_fetch dut (
    .clk(clk), .rst(rst), .rom(rom_bus.master),
    .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
    .call_en(call_en), .call_addr(call_addr), .ret_en(ret_en),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .skip_en(skip_en),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .pc(pc), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump_en = 0; call_en = 0; ret_en = 0; pc_wr_en = 0; skip_en = 0;
  endtask

  // Force the PC and run one normal edge so the IR holds the word at addr.
  task automatic land(input logic [8:0] addr);
    pc_wr_en = 1; pc_wr_data = addr; step(); idle();
    step();
  endtask

  initial begin
    idle();
    jump_addr = '0; call_addr = '0; pc_wr_data = '0;
    rst = 1;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 12'h000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_depth", stack_depth, 0);
    chk("rst_flags", {stack_overflow, stack_underflow}, 0);
    chk("rst_romaddr", rom_bus.rom_addr, 0);

    rst = 0;
    step();
    chk("f0_instr", instr, 12'hA00);
    chk("f0_ipc", instr_pc, 0);
    chk("f0_valid", instr_valid, 1);
    chk("f0_romaddr", rom_bus.rom_addr, 1);
    step();
    chk("f1_instr", instr, 12'hA01);
    chk("f1_ipc", instr_pc, 1);
    chk("f1_romaddr", rom_bus.rom_addr, 2);
    step(); step();
    chk("pre_jmp_ipc", instr_pc, 3);

    jump_en = 1; jump_addr = 9'd25; step(); idle();
    chk("jmp_pc", pc, 25);
    chk("jmp_instr", instr, 12'h000);
    chk("jmp_valid", instr_valid, 0);
    chk("jmp_ipc", instr_pc, 4);
    step();
    chk("jmp2_instr", instr, 12'hA19);
    chk("jmp2_ipc", instr_pc, 25);
    chk("jmp2_valid", instr_valid, 1);

    land(9'd4);
    chk("call_ipc", instr_pc, 4);
    call_en = 1; call_addr = 9'h100; step(); idle();
    chk("call_pc", pc, 9'h100);
    chk("call_depth", stack_depth, 1);
    step();
    ret_en = 1; step(); idle();
    chk("ret_pc", pc, 5);
    chk("ret_depth", stack_depth, 0);
    chk("ret_flags", {stack_overflow, stack_underflow}, 0);

    land(9'd4);
    call_en = 1; call_addr = 9'h100; step(); idle(); step();
    chk("c2_ipc", instr_pc, 9'h100);
    call_en = 1; call_addr = 9'h120; step(); idle(); step();
    chk("c3_ipc", instr_pc, 9'h120);
    chk("c3_depth", stack_depth, 2);
    chk("c3_ovf", stack_overflow, 0);
    call_en = 1; call_addr = 9'h140; step(); idle();
    chk("ovf_pc", pc, 9'h140);
    chk("ovf_depth", stack_depth, 2);
    chk("ovf_flag", stack_overflow, 1);
    step();
    ret_en = 1; step(); idle();
    chk("r1_pc", pc, 9'h121);
    chk("r1_depth", stack_depth, 1);
    step();
    ret_en = 1; step(); idle();
    chk("r2_pc", pc, 9'h101);
    chk("r2_depth", stack_depth, 0);
    chk("r2_unf", stack_underflow, 0);
    step();
    ret_en = 1; step(); idle();
    chk("r3_pc", pc, 9'h101);
    chk("r3_depth", stack_depth, 0);
    chk("r3_unf", stack_underflow, 1);

    land(9'd6);
    chk("skip_pre_ipc", instr_pc, 6);
    skip_en = 1; step(); idle();
    chk("skip_valid", instr_valid, 0);
    chk("skip_ipc", instr_pc, 7);
    chk("skip_instr", instr, 12'h000);
    chk("skip_pc", pc, 8);
    step();
    chk("skip2_ipc", instr_pc, 8);
    chk("skip2_valid", instr_valid, 1);
    chk("skip2_instr", instr, 12'hA08);

    pc_wr_en = 1; pc_wr_data = 9'd511; step(); idle();
    chk("wr_pc", pc, 511);
    chk("wr_valid", instr_valid, 0);
    step();
    chk("wrap_pc", pc, 0);
    chk("wrap_instr", instr, 12'hBFF);
    chk("wrap_ipc", instr_pc, 511);
    step();
    chk("wrap2_pc", pc, 1);

    // Priority and flush combinations (stack1 is 0x101 after the pops).
    ret_en = 1; call_en = 1; jump_en = 1; pc_wr_en = 1;
    call_addr = 9'h030; jump_addr = 9'h040; pc_wr_data = 9'h050;
    step(); idle();
    chk("pri_ret_pc", pc, 9'h101);
    chk("pri_ret_depth", stack_depth, 0);
    call_en = 1; jump_en = 1; pc_wr_en = 1; step(); idle();
    chk("pri_call_pc", pc, 9'h030);
    chk("pri_call_depth", stack_depth, 1);
    jump_en = 1; pc_wr_en = 1; step(); idle();
    chk("pri_jmp_pc", pc, 9'h040);
    pc_wr_en = 1; pc_wr_data = 9'h055; skip_en = 1; step(); idle();
    chk("skipredir_pc", pc, 9'h055);
    chk("skipredir_valid", instr_valid, 0);
    stall = 1; jump_en = 1; jump_addr = 9'h066; step(); idle();
    chk("stallredir_pc", pc, 9'h066);
    chk("stallredir_ipc", instr_pc, 9'h055);

    land(9'd9);
    chk("stall_pre_pc", pc, 10);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 10);
      chk("stall_instr", instr, 12'hA09);
      chk("stall_ipc", instr_pc, 9);
      chk("stall_valid", instr_valid, 1);
      chk("stall_romaddr", rom_bus.rom_addr, 10);
    end
    idle();
    step();
    chk("unstall_instr", instr, 12'hA0A);
    chk("unstall_pc", pc, 11);

    call_en = 1; call_addr = 9'h050; step(); idle();
    call_en = 1; call_addr = 9'h060; step(); idle();
    call_en = 1; call_addr = 9'h070; step(); idle();
    chk("pre_rst_depth", stack_depth, 2);
    chk("pre_rst_ovf", stack_overflow, 1);
    chk("pre_rst_unf", stack_underflow, 1);
    rst = 1; jump_en = 1; jump_addr = 9'h1AA; skip_en = 1;
    step(); idle(); rst = 0;
    chk("rst2_pc", pc, 0);
    chk("rst2_instr", instr, 12'h000);
    chk("rst2_valid", instr_valid, 0);
    chk("rst2_ipc", instr_pc, 0);
    chk("rst2_depth", stack_depth, 0);
    chk("rst2_flags", {stack_overflow, stack_underflow}, 0);
    step();
    chk("rst2_f0_instr", instr, 12'hA00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pic_fetch.md
Name: pic_fetch

Overview:
- Instruction-fetch front end for the 12-bit PIC core.
- Drives the 9-bit address into the combinational program ROM and registers the returned 12-bit word into an instruction register (IR) for decode/execute.
- Owns the program counter, the 2-level hardware return stack, and pipeline flushes for GOTO/CALL/RETLW/PCL writes and skip instructions.

Parameters:
- ADDR_W, 9, program address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 12, instruction width.
- RESET_VECTOR, 9'd0, PC value loaded on reset.
- NOP_INSTR, 12'h000, word placed in the IR when it is flushed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  ROM address; combinationally equal to pc.
- rom_data  in  DATA_W  ROM word for rom_addr, valid in the same cycle.
- stall  in  1  hold PC, IR and stack.
- jump_en  in  1  GOTO redirect.
- jump_addr  in  ADDR_W  GOTO target.
- call_en  in  1  CALL: push, then redirect.
- call_addr  in  ADDR_W  CALL target.
- ret_en  in  1  RETLW: pop, then redirect.
- pc_wr_en  in  1  write to PCL/PC.
- pc_wr_data  in  ADDR_W  new PC value.
- skip_en  in  1  discard the next instruction.
- instr  out  DATA_W  IR contents.
- instr_pc  out  ADDR_W  address the IR word was fetched from.
- instr_valid  out  1  IR holds a real instruction (0 = flushed bubble).
- pc  out  ADDR_W  current fetch PC.
- stack_depth  out  2  valid stack entries, 0..2.
- stack_overflow  out  1  sticky; set by a push when depth is 2.
- stack_underflow  out  1  sticky; set by a pop when depth is 0.

Behaviour:
- Reset (rst=1 at an edge) takes priority over everything:
  - pc=RESET_VECTOR, instr=NOP_INSTR, instr_pc=0, instr_valid=0.
  - stack1=stack2=0, stack_depth=0, both sticky flags=0.
  - Reset mid-operation discards any redirect, stall or skip in that cycle.
- Normal edge (no rst, no redirect, no stall, no skip): instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1. Fetch-to-IR latency is 1 cycle.
- PC wrap: 511+1 -> 0, with no flag.
- Redirect = any of ret_en, call_en, jump_en, pc_wr_en.
  - Priority when several are asserted: ret > call > jump > pc_wr.
  - Target: ret -> stack1; call -> call_addr; jump -> jump_addr; pc_wr -> pc_wr_data.
  - On the edge: pc<=target, instr<=NOP_INSTR, instr_valid<=0, instr_pc<=pc (address of the discarded word).
  - Target word appears in the IR on the following edge, giving a 2-cycle branch.
- Call push: stack2<=stack1, stack1<=pc (return address = instr_pc+1 of the CALL). depth<=min(depth+1,2). If depth was 2: stack_overflow<=1 and the old stack2 is lost.
- Ret pop: stack1<=stack2, stack2 unchanged. depth<=max(depth-1,0). If depth was 0: stack_underflow<=1 and the pop still uses stack1.
- Skip (skip_en, no redirect): pc<=pc+1, instr<=NOP_INSTR, instr_valid<=0, instr_pc<=pc. The skipped word is never valid.
- Skip and redirect together: redirect wins; the flush behaviour is identical.
- Stall with no redirect: pc, IR, instr_pc, instr_valid and the stack all hold, and rom_addr stays constant.
- Stall together with a redirect: the redirect executes (stall ignored for that edge).
- Sticky flags clear only on rst.
- Outputs other than rom_addr are registered.

Test Plan:
- ROM model returns {3'b101, addr}. Release rst -> rom_addr 0,1,2; instr 0xA00, then 0xA01; instr_pc 0,1; instr_valid 0 in the reset cycle, then 1.
- jump_en, jump_addr=25 while instr_pc=3 -> next edge: pc=25, instr=0x000, instr_valid=0. Following edge: instr=0xA19, instr_pc=25, valid=1.
- call_en, call_addr=0x100 at instr_pc=4 -> stack1=5, depth=1, pc=0x100. Later ret_en -> pc=5, depth=0, flags 0.
- CALLs issued at instr_pc 4, 0x100 and 0x120 -> depth stays 2, stack_overflow=1. Three rets -> pcs 0x121, 0x101, 0x101; stack_underflow=1 on the third.
- skip_en at instr_pc=6 -> next edge: instr_valid=0, instr_pc=7. Then instr_pc=8, valid=1. Also force pc=511 via pc_wr, then run 2 edges -> pc wraps to 0.
- stall held 3 cycles at pc=10 -> pc/instr unchanged. Assert rst with depth=2 and overflow=1 -> next edge all reset values.
